// File: rtl/accum_seq_pkg.sv
// Shared encodings and default sizing for the accumulator sequencer.
package accum_seq_pkg;

  localparam int PIX_W_DEF     = 8;
  localparam int LOG2_NPIX_DEF = 14;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_ACCUM = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/accum_seq_ctrl_pix_counter.sv
// Pixel counter: synchronous clear, enable-increment, terminal-count flag.
module pix_counter #(
  parameter int           W   = 15,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // next count: clear wins over increment
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == MAX);

endmodule

// File: rtl/accum_seq_ctrl.sv
// Per-frame sequencer for the external running-sum accumulator: clears it,
// streams one frame of pixels in, waits out its register latency, then
// captures the frame sum and mean.
//
// Pixel handshake: a pixel transfers in a cycle iff pix_valid & pix_ready.
// pix_ready is a function of state and abort only (never of pix_valid), and
// acc_add carries pix_data only in a transfer cycle, zero otherwise, so the
// accumulator never re-adds a stalled pixel.
module accum_seq_ctrl
  import accum_seq_pkg::*;
#(
  parameter  int PIX_W     = PIX_W_DEF,
  parameter  int LOG2_NPIX = LOG2_NPIX_DEF,
  localparam int SUM_W     = PIX_W + LOG2_NPIX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_ready,
  output logic [PIX_W-1:0] acc_add,
  output logic             acc_reset_add,
  input  logic [SUM_W-1:0] acc_sum,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] sum_out,
  output logic [PIX_W-1:0] mean_out
);

  // last pixel index of a frame; count is one bit wider so it cannot wrap
  localparam logic [LOG2_NPIX:0] CNT_MAX = {1'b0, {LOG2_NPIX{1'b1}}};

  logic [1:0]       state_q, state_d;
  logic             done_q, done_d;
  logic [SUM_W-1:0] sum_out_q, sum_out_d;
  logic [PIX_W-1:0] mean_out_q, mean_out_d;
  logic             transfer;
  logic             cnt_tc;

  // handshake and accumulator drive; abort suppresses any transfer
  always_comb begin
    pix_ready     = (state_q == ST_ACCUM) && !abort;
    transfer      = pix_ready && pix_valid;
    acc_add       = transfer ? pix_data : '0;
    acc_reset_add = (state_q == ST_CLEAR) || abort;
    busy          = (state_q != ST_IDLE);
  end

  pix_counter #(
    .W   (LOG2_NPIX + 1),
    .MAX (CNT_MAX)
  ) u_pix_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == ST_CLEAR),
    .en    (transfer),
    .tc    (cnt_tc)
  );

  // next-state logic; abort returns to IDLE from any state
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_CLEAR;
        ST_CLEAR: state_d = ST_ACCUM;
        ST_ACCUM: if (transfer && cnt_tc) state_d = ST_DRAIN;
        ST_DRAIN: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // result capture: in DRAIN the accumulator already holds the last pixel
  always_comb begin
    done_d     = (state_q == ST_DRAIN) && !abort;
    sum_out_d  = sum_out_q;
    mean_out_d = mean_out_q;
    if (done_d) begin
      sum_out_d  = acc_sum;
      mean_out_d = acc_sum[SUM_W-1 -: PIX_W];
    end
  end

  // state and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      sum_out_q  <= '0;
      mean_out_q <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      sum_out_q  <= sum_out_d;
      mean_out_q <= mean_out_d;
    end
  end

  assign done     = done_q;
  assign sum_out  = sum_out_q;
  assign mean_out = mean_out_q;

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// Bench for accum_seq_ctrl with 4-pixel frames and a running-sum
// accumulator model attached to acc_add/acc_reset_add/acc_sum.
module tb_accum_seq_ctrl;

  localparam int PIX_W     = 8;
  localparam int LOG2_NPIX = 2;
  localparam int SUM_W     = PIX_W + LOG2_NPIX;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             reset, start, abort, pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             pix_ready, acc_reset_add, busy, done;
  logic [PIX_W-1:0] acc_add, mean_out;
  logic [SUM_W-1:0] acc_sum, sum_out;

  always #5 clk = ~clk;

  accum_seq_ctrl #(.PIX_W(PIX_W), .LOG2_NPIX(LOG2_NPIX)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .pix_valid     (pix_valid),
    .pix_data      (pix_data),
    .pix_ready     (pix_ready),
    .acc_add       (acc_add),
    .acc_reset_add (acc_reset_add),
    .acc_sum       (acc_sum),
    .busy          (busy),
    .done          (done),
    .sum_out       (sum_out),
    .mean_out      (mean_out)
  );

  // accumulator: ADD in cycle t visible on SUM from t+1; reset_add clears at next edge
  logic [SUM_W-1:0] acc_q = '0;
  always @(posedge clk) begin
    if (acc_reset_add) acc_q <= '0;
    else               acc_q <= acc_q + {{LOG2_NPIX{1'b0}}, acc_add};
  end
  assign acc_sum = acc_q;

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic s, input logic a, input logic v, input logic [7:0] d);
    start = s; abort = a; pix_valid = v; pix_data = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_after_reset(input string tag);
    chk({tag, " busy"},  32'(busy), 0);
    chk({tag, " done"},  32'(done), 0);
    chk({tag, " sum"},   32'(sum_out), 0);
    chk({tag, " mean"},  32'(mean_out), 0);
    chk({tag, " ready"}, 32'(pix_ready), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             s, a, v;
    logic [7:0]       d;
    logic             busy, ready;
    logic [7:0]       add;
    logic             rst, done;
    logic [SUM_W-1:0] sum;
    logic [7:0]       mean;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic a, logic v, logic [7:0] d,
                              logic b, logic r, logic [7:0] ad, logic ra,
                              logic dn, logic [SUM_W-1:0] sm, logic [7:0] mn);
    vec_t t;
    t.s = s; t.a = a; t.v = v; t.d = d;
    t.busy = b; t.ready = r; t.add = ad; t.rst = ra;
    t.done = dn; t.sum = sm; t.mean = mn;
    return t;
  endfunction

  task automatic build_table();
    // 1: 10,20,30,40 back to back -> 100 / 25, done two cycles after last pixel
    vecs.push_back(mk(1,0,0,  0, 0,0,  0,0,0,   0,  0));
    vecs.push_back(mk(0,0,1, 10, 1,0,  0,1,0,   0,  0));
    vecs.push_back(mk(0,0,1, 10, 1,1, 10,0,0,   0,  0));
    vecs.push_back(mk(0,0,1, 20, 1,1, 20,0,0,   0,  0));
    vecs.push_back(mk(0,0,1, 30, 1,1, 30,0,0,   0,  0));
    vecs.push_back(mk(0,0,1, 40, 1,1, 40,0,0,   0,  0));
    vecs.push_back(mk(0,0,1, 99, 1,0,  0,0,0,   0,  0));
    vecs.push_back(mk(0,0,0,  0, 0,0,  0,0,1, 100, 25));
    // 2: 255 x4 with 3 stall cycles between, stale data on the bus while stalled
    vecs.push_back(mk(1,0,0,  0, 0,0,  0,0,0, 100, 25));
    vecs.push_back(mk(0,0,0,  0, 1,0,  0,1,0, 100, 25));
    for (int k = 0; k < 4; k++) begin
      vecs.push_back(mk(0,0,1,255, 1,1,255,0,0, 100, 25));
      if (k < 3)
        for (int j = 0; j < 3; j++)
          vecs.push_back(mk(0,0,0,8'hAA, 1,1,0,0,0, 100, 25));
    end
    vecs.push_back(mk(0,0,0,  0, 1,0,  0,0,0, 100, 25));
    vecs.push_back(mk(0,0,0,  0, 0,0,  0,0,1,1020,255));
    // 3: frame 1,2,3,4 then start in the done cycle, frame 5,5,5,5
    vecs.push_back(mk(1,0,0,  0, 0,0,  0,0,0,1020,255));
    vecs.push_back(mk(0,0,1,  1, 1,0,  0,1,0,1020,255));
    for (int p = 1; p <= 4; p++)
      vecs.push_back(mk(0,0,1, 8'(p), 1,1, 8'(p),0,0,1020,255));
    vecs.push_back(mk(0,0,1,  9, 1,0,  0,0,0,1020,255));
    vecs.push_back(mk(1,0,0,  0, 0,0,  0,0,1,  10,  2));
    vecs.push_back(mk(0,0,1,  5, 1,0,  0,1,0,  10,  2));
    for (int p = 0; p < 4; p++)
      vecs.push_back(mk(0,0,1,  5, 1,1,  5,0,0,  10,  2));
    vecs.push_back(mk(0,0,0,  0, 1,0,  0,0,0,  10,  2));
    vecs.push_back(mk(0,0,0,  0, 0,0,  0,0,1,  20,  5));
    // 4: abort after two 7s, no done, then frame of 1s -> 4 / 1
    vecs.push_back(mk(1,0,0,  0, 0,0,  0,0,0,  20,  5));
    vecs.push_back(mk(0,0,1,  7, 1,0,  0,1,0,  20,  5));
    vecs.push_back(mk(0,0,1,  7, 1,1,  7,0,0,  20,  5));
    vecs.push_back(mk(0,0,1,  7, 1,1,  7,0,0,  20,  5));
    vecs.push_back(mk(0,1,1,  7, 1,0,  0,1,0,  20,  5));
    vecs.push_back(mk(0,0,1,  7, 0,0,  0,0,0,  20,  5));
    vecs.push_back(mk(0,0,0,  0, 0,0,  0,0,0,  20,  5));
    vecs.push_back(mk(1,0,0,  0, 0,0,  0,0,0,  20,  5));
    vecs.push_back(mk(0,0,1,  1, 1,0,  0,1,0,  20,  5));
    for (int p = 0; p < 4; p++)
      vecs.push_back(mk(0,0,1,  1, 1,1,  1,0,0,  20,  5));
    vecs.push_back(mk(0,0,0,  0, 1,0,  0,0,0,  20,  5));
    vecs.push_back(mk(0,0,0,  0, 0,0,  0,0,1,   4,  1));
    // abort during DRAIN: the frame of 3s never lands
    vecs.push_back(mk(1,0,0,  0, 0,0,  0,0,0,   4,  1));
    vecs.push_back(mk(0,0,0,  0, 1,0,  0,1,0,   4,  1));
    for (int p = 0; p < 4; p++)
      vecs.push_back(mk(0,0,1,  3, 1,1,  3,0,0,   4,  1));
    vecs.push_back(mk(0,1,0,  0, 1,0,  0,1,0,   4,  1));
    vecs.push_back(mk(0,0,0,  0, 0,0,  0,0,0,   4,  1));
    // 6: start and abort together in IDLE; abort alone in IDLE
    vecs.push_back(mk(1,1,0,  0, 0,0,  0,1,0,   4,  1));
    vecs.push_back(mk(0,0,0,  0, 0,0,  0,0,0,   4,  1));
    vecs.push_back(mk(0,1,0,  0, 0,0,  0,1,0,   4,  1));
    vecs.push_back(mk(0,0,0,  0, 0,0,  0,0,0,   4,  1));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit seen;
    reset = 1'b1;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk_idle_after_reset("reset");
    chk("reset rst_add", 32'(acc_reset_add), 0);

    build_table();
    foreach (vecs[i]) begin
      drive(vecs[i].s, vecs[i].a, vecs[i].v, vecs[i].d);
      #1;
      chk($sformatf("v%0d busy",  i), 32'(busy),          32'(vecs[i].busy));
      chk($sformatf("v%0d ready", i), 32'(pix_ready),     32'(vecs[i].ready));
      chk($sformatf("v%0d add",   i), 32'(acc_add),       32'(vecs[i].add));
      chk($sformatf("v%0d rst",   i), 32'(acc_reset_add), 32'(vecs[i].rst));
      chk($sformatf("v%0d done",  i), 32'(done),          32'(vecs[i].done));
      chk($sformatf("v%0d sum",   i), 32'(sum_out),       32'(vecs[i].sum));
      chk($sformatf("v%0d mean",  i), 32'(mean_out),      32'(vecs[i].mean));
      @(posedge clk);
      #1;
    end

    // 5a: reset in ACCUM after two pixels
    drive(1, 0, 0, 0); step();
    drive(0, 0, 1, 9); step();
    step(); step();
    reset = 1'b1; step();
    reset = 1'b0; drive(0, 0, 0, 0); #1;
    chk_idle_after_reset("rst_accum");

    // start held high while busy must not disturb the frame: 2,4,6,8 -> 20 / 5
    drive(1, 0, 0, 0); step();
    step();
    for (int p = 1; p <= 4; p++) begin
      drive(1, 0, 1, 8'(2 * p)); step();
    end
    drive(0, 0, 0, 0); #1;
    chk("busy_start drain busy", 32'(busy), 1);
    step();
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (done) seen = 1'b1;
      else step();
    end
    chk("busy_start done seen", 32'(seen), 1);
    chk("busy_start sum",  32'(sum_out), 20);
    chk("busy_start mean", 32'(mean_out), 5);
    step();

    // 5b: reset in DRAIN discards the frame and clears the result
    drive(1, 0, 0, 0); step();
    drive(0, 0, 1, 1); step();
    for (int p = 0; p < 4; p++) step();
    drive(0, 0, 0, 0); #1;
    chk("rst_drain pre busy",  32'(busy), 1);
    chk("rst_drain pre ready", 32'(pix_ready), 0);
    reset = 1'b1; step();
    reset = 1'b0; #1;
    chk_idle_after_reset("rst_drain");
    step();
    chk("rst_drain later done", 32'(done), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
